video_write_scheduler: RTL and testbench
========================================

Name: video_write_scheduler

Overview:
Single-owner sequencer for the video memory write port (video_write/video_address/video_value/video_mask). It merges two requesters onto that port:
- TPU single-cell writes, using a valid/ready handshake.
- A built-in bulk fill engine that writes one value/mask to a run of consecutive cells, used for screen clear, line erase and attribute fill.

It sits between tpu and video_memory. When both requesters contend, they share the port with strict alternation.

Parameters:
ADDR_WIDTH, 16, video memory address width; fill addresses wrap modulo 2^ADDR_WIDTH
DATA_WIDTH, 24, width of value and mask
COUNT_WIDTH, 16, width of fill cell count

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
tpu_write  input  1  TPU write request (valid)
tpu_address  input  ADDR_WIDTH  TPU target cell
tpu_value  input  DATA_WIDTH  TPU cell value
tpu_mask  input  DATA_WIDTH  TPU bit mask
tpu_ready  output  1  combinational; TPU write accepted in a cycle where tpu_write & tpu_ready
fill_start  input  1  single-cycle fill command strobe
fill_address  input  ADDR_WIDTH  first cell of fill
fill_count  input  COUNT_WIDTH  number of cells; 0 = no-op
fill_value  input  DATA_WIDTH  value written to every cell
fill_mask  input  DATA_WIDTH  mask applied to every cell
fill_busy  output  1  registered; fill in progress
fill_done  output  1  registered; one-cycle completion pulse
video_write  output  1  registered write strobe to video_memory
video_address  output  ADDR_WIDTH  registered
video_value  output  DATA_WIDTH  registered
video_mask  output  DATA_WIDTH  registered

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all outputs 0 except tpu_ready = 1. Internal state: FSM IDLE, prio_tpu = 1, counters 0.
- Reset mid-fill: the fill is aborted with no fill_done pulse. Writes already issued are not undone.
- FSM states: IDLE, FILL.
- IDLE:
  - fill_start with fill_count != 0 → FILL. On that edge, latch address/value/mask, set remaining = fill_count, prio_tpu <= 1, fill_busy <= 1.
  - fill_start with fill_count = 0: stay IDLE, fill_done pulses next cycle, no writes, fill_busy stays 0.
- FILL:
  - fill_start is ignored, with no effect on the latched command.
- Arbitration (combinational):
  - filling = (state == FILL).
  - grant_tpu = tpu_write & (~filling | prio_tpu).
  - grant_fill = filling & ~grant_tpu.
  - tpu_ready = ~filling | prio_tpu.
- Priority update while filling:
  - grant_tpu → prio_tpu <= 0.
  - grant_fill → prio_tpu <= 1.
  - Effect: strict T,F,T,F alternation under contention, with the TPU first on fill entry. The fill uses every slot the TPU leaves idle.
- Output register, one-cycle latency: the grant in cycle N drives the port in cycle N+1.
  - video_write <= grant_tpu | grant_fill.
  - Address/value/mask take the granted source's fields.
  - With no grant, video_write <= 0 and address/value/mask hold their previous values.
- Fill addressing:
  - Each grant_fill issues the current address, then address <= address + 1 modulo 2^ADDR_WIDTH (0xFFFF → 0x0000) and remaining <= remaining − 1.
- Fill completion, on the grant_fill with remaining == 1:
  - Next edge: FSM → IDLE, fill_busy <= 0, fill_done <= 1.
  - fill_done coincides with the final fill write on video_write. It pulses for exactly one cycle.
- fill_start coinciding with tpu_write in IDLE: the TPU is granted in that cycle. The first fill slot is the next cycle, where prio_tpu = 1 gives a pending TPU request that slot first.
- Back-to-back fills: a new fill_start is accepted in the cycle fill_done is high, since the FSM is already IDLE.

Test Plan:
- TPU only: tpu_write=1, addr 0x1234, value 0xABCDEF, mask 0xFFFFFF for 1 cycle → tpu_ready=1; next cycle video_write=1 with 0x1234/0xABCDEF/0xFFFFFF; following cycle video_write=0, fields held.
- Wrap fill: fill_start, address 0xFFFE, count 4, value 0x000070, TPU idle → video_write high 4 consecutive cycles at 0xFFFE, 0xFFFF, 0x0000, 0x0001; fill_done high with the 4th write only; fill_busy falls same cycle.
- Contention: fill 0x0100 count 3, tpu_write held high with addresses 0x0A00, 0x0A01, 0x0A02 → port order 0x0A00, 0x0100, 0x0A01, 0x0101, 0x0A02, 0x0102; fill_done with 0x0102; tpu_ready low on each fill slot.
- Zero count: fill_start with count 0 → no video_write; fill_busy stays 0; fill_done pulses once the next cycle.
- Ignored restart: second fill_start (address 0x2000) during a count-8 fill at 0x0000 → exactly 8 writes, 0x0000–0x0007; single fill_done.
- Reset mid-fill: reset after 2 of 10 fill writes → next cycle all outputs 0, tpu_ready=1, no fill_done; a new TPU write is then granted immediately.

Source files
------------

// File: rtl/video_write_scheduler.sv
// Single owner of the video memory write port: merges TPU single-cell writes with a
// bulk fill engine, alternating strictly between them when both want the port.
module video_write_scheduler #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 24,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   tpu_write,
    input  logic [ADDR_WIDTH-1:0]  tpu_address,
    input  logic [DATA_WIDTH-1:0]  tpu_value,
    input  logic [DATA_WIDTH-1:0]  tpu_mask,
    output logic                   tpu_ready,

    input  logic                   fill_start,
    input  logic [ADDR_WIDTH-1:0]  fill_address,
    input  logic [COUNT_WIDTH-1:0] fill_count,
    input  logic [DATA_WIDTH-1:0]  fill_value,
    input  logic [DATA_WIDTH-1:0]  fill_mask,
    output logic                   fill_busy,
    output logic                   fill_done,

    output logic                   video_write,
    output logic [ADDR_WIDTH-1:0]  video_address,
    output logic [DATA_WIDTH-1:0]  video_value,
    output logic [DATA_WIDTH-1:0]  video_mask
);

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e                 state_q;
    logic                   prio_tpu_q;
    logic [ADDR_WIDTH-1:0]  fill_addr_q;
    logic [COUNT_WIDTH-1:0] fill_remaining_q;
    logic [DATA_WIDTH-1:0]  fill_value_q;
    logic [DATA_WIDTH-1:0]  fill_mask_q;

    logic filling;
    logic grant_tpu;
    logic grant_fill;
    logic fill_last;

    always_comb begin
        filling    = (state_q == StFill);
        grant_tpu  = tpu_write & (~filling | prio_tpu_q);
        grant_fill = filling & ~grant_tpu;
        fill_last  = grant_fill & (fill_remaining_q == COUNT_WIDTH'(1));
    end

    assign tpu_ready = ~filling | prio_tpu_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StIdle;
            prio_tpu_q       <= 1'b1;
            fill_addr_q      <= '0;
            fill_remaining_q <= '0;
            fill_value_q     <= '0;
            fill_mask_q      <= '0;
            fill_busy        <= 1'b0;
            fill_done        <= 1'b0;
            video_write      <= 1'b0;
            video_address    <= '0;
            video_value      <= '0;
            video_mask       <= '0;
        end else begin
            fill_done   <= 1'b0;
            video_write <= grant_tpu | grant_fill;

            // Port fields hold their last value when nobody is granted.
            if (grant_tpu) begin
                video_address <= tpu_address;
                video_value   <= tpu_value;
                video_mask    <= tpu_mask;
            end else if (grant_fill) begin
                video_address <= fill_addr_q;
                video_value   <= fill_value_q;
                video_mask    <= fill_mask_q;
            end

            unique case (state_q)
                StIdle: begin
                    if (fill_start) begin
                        if (fill_count != '0) begin
                            state_q          <= StFill;
                            fill_addr_q      <= fill_address;
                            fill_remaining_q <= fill_count;
                            fill_value_q     <= fill_value;
                            fill_mask_q      <= fill_mask;
                            prio_tpu_q       <= 1'b1;
                            fill_busy        <= 1'b1;
                        end else begin
                            fill_done <= 1'b1;
                        end
                    end
                end
                StFill: begin
                    // fill_start is deliberately ignored here.
                    if (grant_tpu) begin
                        prio_tpu_q <= 1'b0;
                    end
                    if (grant_fill) begin
                        prio_tpu_q       <= 1'b1;
                        fill_addr_q      <= fill_addr_q + ADDR_WIDTH'(1);
                        fill_remaining_q <= fill_remaining_q - COUNT_WIDTH'(1);
                    end
                    if (fill_last) begin
                        state_q   <= StIdle;
                        fill_busy <= 1'b0;
                        fill_done <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_video_write_scheduler.sv
// Bench for video_write_scheduler: directed vector table, then random traffic checked
// against a cell-level reference model of the port.
module tb_video_write_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        tpu_write;
    logic [15:0] tpu_address;
    logic [23:0] tpu_value;
    logic [23:0] tpu_mask;
    logic        tpu_ready;
    logic        fill_start;
    logic [15:0] fill_address;
    logic [15:0] fill_count;
    logic [23:0] fill_value;
    logic [23:0] fill_mask;
    logic        fill_busy;
    logic        fill_done;
    logic        video_write;
    logic [15:0] video_address;
    logic [23:0] video_value;
    logic [23:0] video_mask;

    always #5 clk = ~clk;

    video_write_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .tpu_write    (tpu_write),
        .tpu_address  (tpu_address),
        .tpu_value    (tpu_value),
        .tpu_mask     (tpu_mask),
        .tpu_ready    (tpu_ready),
        .fill_start   (fill_start),
        .fill_address (fill_address),
        .fill_count   (fill_count),
        .fill_value   (fill_value),
        .fill_mask    (fill_mask),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .video_write  (video_write),
        .video_address(video_address),
        .video_value  (video_value),
        .video_mask   (video_mask)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a fill is just "cells left" plus the next cell address; the
    // TPU gets every other slot while a fill is pending.
    int          m_left;
    logic [15:0] m_next;
    logic [23:0] m_fv, m_fm;
    bit          m_tpu_turn;
    logic        m_vw, m_busy, m_done;
    logic [15:0] m_va;
    logic [23:0] m_vv, m_vm;

    task automatic model_reset();
        m_left = 0; m_next = '0; m_fv = '0; m_fm = '0; m_tpu_turn = 1'b1;
        m_vw = 0; m_busy = 0; m_done = 0; m_va = '0; m_vv = '0; m_vm = '0;
    endtask

    // Inputs must be stable; checks tpu_ready before the edge and all registered
    // outputs just after it.
    task automatic tick();
        bit filling, m_ready, tw, fw;
        @(negedge clk);
        filling = (m_left > 0);
        m_ready = !filling || m_tpu_turn;
        chk("tpu_ready", 32'(tpu_ready), 32'(m_ready));
        if (reset) begin
            model_reset();
        end else begin
            tw = tpu_write && m_ready;
            fw = filling && !tw;
            m_vw = tw || fw;
            m_done = 0;
            if (tw) begin
                m_va = tpu_address; m_vv = tpu_value; m_vm = tpu_mask;
            end else if (fw) begin
                m_va = m_next; m_vv = m_fv; m_vm = m_fm;
            end
            if (fw) begin
                m_next = m_next + 16'd1;
                m_left--;
                m_tpu_turn = 1'b1;
                if (m_left == 0) m_done = 1;
            end else if (tw && filling) begin
                m_tpu_turn = 1'b0;
            end
            if (!filling && fill_start) begin
                if (fill_count == 16'd0) begin
                    m_done = 1;
                end else begin
                    m_left = int'(fill_count); m_next = fill_address;
                    m_fv = fill_value; m_fm = fill_mask; m_tpu_turn = 1'b1;
                end
            end
            m_busy = (m_left > 0);
        end
        @(posedge clk);
        #1;
        chk("video_write", 32'(video_write), 32'(m_vw));
        chk("video_address", 32'(video_address), 32'(m_va));
        chk("video_value", 32'(video_value), 32'(m_vv));
        chk("video_mask", 32'(video_mask), 32'(m_vm));
        chk("fill_busy", 32'(fill_busy), 32'(m_busy));
        chk("fill_done", 32'(fill_done), 32'(m_done));
    endtask

    typedef struct {
        logic        tw;
        logic [15:0] ta;
        logic        fs;
        logic [15:0] fa;
        logic [15:0] fc;
        logic        rst;
        logic        er;
        logic        ew;
        logic [15:0] ea;
        logic        eb;
        logic        ed;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic tw, input logic [15:0] ta, input logic fs,
                       input logic [15:0] fa, input logic [15:0] fc, input logic rst,
                       input logic er, input logic ew, input logic [15:0] ea,
                       input logic eb, input logic ed);
        vec_t v;
        v.tw = tw; v.ta = ta; v.fs = fs; v.fa = fa; v.fc = fc; v.rst = rst;
        v.er = er; v.ew = ew; v.ea = ea; v.eb = eb; v.ed = ed;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        reset = 0; tpu_write = 0; tpu_address = '0; tpu_value = '0; tpu_mask = '0;
        fill_start = 0; fill_address = '0; fill_count = '0; fill_value = '0; fill_mask = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        //   tw ta       fs fa       fc     rst  er ew ea       eb ed
        add(0, 16'h0000, 0, 16'h0000, 16'd0, 1,  1, 0, 16'h0000, 0, 0);
        // TPU only
        add(1, 16'h1234, 0, 16'h0000, 16'd0, 0,  1, 1, 16'h1234, 0, 0);
        add(0, 16'h0000, 0, 16'h0000, 16'd0, 0,  1, 0, 16'h1234, 0, 0);
        // Fill wrapping past 0xFFFF
        add(0, 16'h0000, 1, 16'hFFFE, 16'd4, 0,  1, 0, 16'h1234, 1, 0);
        add(0, 16'h0000, 0, 16'h0000, 16'd0, 0,  1, 1, 16'hFFFE, 1, 0);
        add(0, 16'h0000, 0, 16'h0000, 16'd0, 0,  1, 1, 16'hFFFF, 1, 0);
        add(0, 16'h0000, 0, 16'h0000, 16'd0, 0,  1, 1, 16'h0000, 1, 0);
        add(0, 16'h0000, 0, 16'h0000, 16'd0, 0,  1, 1, 16'h0001, 0, 1);
        add(0, 16'h0000, 0, 16'h0000, 16'd0, 0,  1, 0, 16'h0001, 0, 0);
        // Contention: T,F,T,F,T,F
        add(0, 16'h0000, 1, 16'h0100, 16'd3, 0,  1, 0, 16'h0001, 1, 0);
        add(1, 16'h0A00, 0, 16'h0000, 16'd0, 0,  1, 1, 16'h0A00, 1, 0);
        add(1, 16'h0A01, 0, 16'h0000, 16'd0, 0,  0, 1, 16'h0100, 1, 0);
        add(1, 16'h0A01, 0, 16'h0000, 16'd0, 0,  1, 1, 16'h0A01, 1, 0);
        add(1, 16'h0A02, 0, 16'h0000, 16'd0, 0,  0, 1, 16'h0101, 1, 0);
        add(1, 16'h0A02, 0, 16'h0000, 16'd0, 0,  1, 1, 16'h0A02, 1, 0);
        add(0, 16'h0000, 0, 16'h0000, 16'd0, 0,  0, 1, 16'h0102, 0, 1);
        add(0, 16'h0000, 0, 16'h0000, 16'd0, 0,  1, 0, 16'h0102, 0, 0);
        // Zero-count fill
        add(0, 16'h0000, 1, 16'h3333, 16'd0, 0,  1, 0, 16'h0102, 0, 1);
        add(0, 16'h0000, 0, 16'h0000, 16'd0, 0,  1, 0, 16'h0102, 0, 0);
        // Restart during a fill is ignored
        add(0, 16'h0000, 1, 16'h0000, 16'd8, 0,  1, 0, 16'h0102, 1, 0);
        for (int i = 0; i < 8; i++) begin
            add(0, 16'h0000, logic'(i == 1), 16'h2000, 16'd5, 0,
                1, 1, 16'(i), logic'(i != 7), logic'(i == 7));
        end
        add(0, 16'h0000, 0, 16'h0000, 16'd0, 0,  1, 0, 16'h0007, 0, 0);
        // Reset after 2 of 10 fill writes
        add(0, 16'h0000, 1, 16'h0500, 16'd10, 0, 1, 0, 16'h0007, 1, 0);
        add(0, 16'h0000, 0, 16'h0000, 16'd0, 0,  1, 1, 16'h0500, 1, 0);
        add(0, 16'h0000, 0, 16'h0000, 16'd0, 0,  1, 1, 16'h0501, 1, 0);
        add(0, 16'h0000, 0, 16'h0000, 16'd0, 1,  1, 0, 16'h0000, 0, 0);
        add(1, 16'h0BEE, 0, 16'h0000, 16'd0, 0,  1, 1, 16'h0BEE, 0, 0);
        add(0, 16'h0000, 0, 16'h0000, 16'd0, 0,  1, 0, 16'h0BEE, 0, 0);
        add(0, 16'h0000, 0, 16'h0000, 16'd0, 0,  1, 0, 16'h0BEE, 0, 0);

        foreach (vecs[i]) begin
            idle_inputs();
            reset        = vecs[i].rst;
            tpu_write    = vecs[i].tw;
            tpu_address  = vecs[i].ta;
            tpu_value    = 24'hABCDEF;
            tpu_mask     = 24'hFFFFFF;
            fill_start   = vecs[i].fs;
            fill_address = vecs[i].fa;
            fill_count   = vecs[i].fc;
            fill_value   = 24'h000070;
            fill_mask    = 24'h0F0F0F;
            #3;
            chk($sformatf("vec%0d tpu_ready", i), 32'(tpu_ready), 32'(vecs[i].er));
            tick();
            chk($sformatf("vec%0d video_write", i), 32'(video_write), 32'(vecs[i].ew));
            chk($sformatf("vec%0d video_address", i), 32'(video_address), 32'(vecs[i].ea));
            chk($sformatf("vec%0d fill_busy", i), 32'(fill_busy), 32'(vecs[i].eb));
            chk($sformatf("vec%0d fill_done", i), 32'(fill_done), 32'(vecs[i].ed));
        end

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            idle_inputs();
            reset       = ($urandom_range(0, 299) == 0);
            tpu_write   = ($urandom_range(0, 99) < 55);
            tpu_address = 16'($urandom);
            tpu_value   = 24'($urandom);
            tpu_mask    = 24'($urandom);
            fill_start  = ($urandom_range(0, 99) < 8);
            fill_address = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                                       : 16'($urandom);
            fill_count  = 16'($urandom_range(0, 7));
            fill_value  = 24'($urandom);
            fill_mask   = 24'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
